// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] dvd_r;    // shifts dividend out the top, quotient in the bottom
  logic [N-1:0]   dvs_r;
  logic [N:0]     prem;
  logic [N:0]     shifted, trial, prem_nxt;
  logic           q_bit;
  logic           last_iter;

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign last_iter = (cnt == CW'(1));

  // Partial remainder stays below 2*divisor, so an N+1-bit difference has
  // MSB set exactly when the trial subtraction goes negative.
  always_comb begin
    shifted  = {prem[N-1:0], dvd_r[2*N-1]};
    trial    = shifted - {1'b0, dvs_r};
    q_bit    = ~trial[N];
    prem_nxt = q_bit ? trial : shifted;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      prem      <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend[N-1:0];
            dbz       <= 1'b1;
          end else begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            prem  <= '0;
            cnt   <= CW'(2*N);
          end
        end
        CALC: begin
          prem  <= prem_nxt;
          dvd_r <= {dvd_r[2*N-2:0], q_bit};
          cnt   <= cnt - CW'(1);
          if (last_iter) begin
            quotient  <= {dvd_r[2*N-2:0], q_bit};
            remainder <= prem_nxt[N-1:0];
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (N=16): results, latency,
// divide-by-zero, start protocol, async reset and a short random sweep.
module tb_seq_restoring_divider;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy, done, dbz;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // lat = negedge index (after accept edge) where done is seen, -1 on timeout
  task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic check_res(input string nm, input logic [2*N-1:0] eq,
                           input logic [N-1:0] er, input logic ed,
                           input int lat, input int elat);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, elat);
    end
    checks++;
    if (quotient !== eq) begin
      errors++; $display("FAIL %s quotient got %h want %h", nm, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++; $display("FAIL %s remainder got %h want %h", nm, remainder, er);
    end
    checks++;
    if (dbz !== ed) begin
      errors++; $display("FAIL %s dbz got %b want %b", nm, dbz, ed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset outputs got b%b d%b z%b q%h r%h want all 0",
               busy, done, dbz, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(32'd100, 16'd7, lat, bc);
    check_res("basic_100_7", 32'd14, 16'd2, 1'b0, lat, 33);
    checks++;
    if (bc !== 32) begin
      errors++; $display("FAIL basic_busy_cycles got %0d want 32", bc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle got %b want 0", done);
    end
  endtask

  task automatic test_inverse();
    int lat, bc;
    run_op(32'hFFFE0001, 16'hFFFF, lat, bc);
    check_res("inv_ffff_sq", 32'h0000FFFF, 16'h0, 1'b0, lat, 33);
    run_op(32'hFFFFFFFF, 16'h0001, lat, bc);
    check_res("div_by_one", 32'hFFFFFFFF, 16'h0, 1'b0, lat, 33);
  endtask

  task automatic test_small();
    int lat, bc;
    run_op(32'd5, 16'd9, lat, bc);
    check_res("small_5_9", 32'd0, 16'd5, 1'b0, lat, 33);
    run_op(32'd0, 16'd3, lat, bc);
    check_res("zero_3", 32'd0, 16'd0, 1'b0, lat, 33);
  endtask

  task automatic test_dbz();
    int lat, bc;
    run_op(32'h12345678, 16'h0, lat, bc);
    check_res("dbz", 32'hFFFFFFFF, 16'h5678, 1'b1, lat, 1);
    checks++;
    if (bc !== 0) begin
      errors++; $display("FAIL dbz_busy got %0d want 0", bc);
    end
    run_op(32'd100, 16'd7, lat, bc);
    check_res("after_dbz", 32'd14, 16'd2, 1'b0, lat, 33);
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 10) begin start = 1'b1; dividend = 32'd50; divisor = 16'd5; end
      if (i == 11) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check_res("ignore_start", 32'd14, 16'd2, 1'b0, lat, 33);
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n = 0;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 16'd7;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (done) begin t[n] = i; n++; end
    end
    start = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", n);
    end else begin
      checks++;
      if (t[1] - t[0] !== 34 || t[2] - t[1] !== 34) begin
        errors++; $display("FAIL b2b_period got %0d,%0d want 34,34", t[1]-t[0], t[2]-t[1]);
      end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_mid got b%b d%b z%b q%h r%h want all 0",
               busy, done, dbz, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(32'd1000, 16'd10, lat, bc);
    check_res("after_reset", 32'd100, 16'd0, 1'b0, lat, 33);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic [63:0]    prod;
    for (int k = 0; k < 200; k++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 16'h0001;
        1: b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      if (b == '0) b = 16'd1;
      run_op(a, b, lat, bc);
      prod = 64'(quotient) * 64'(b) + 64'(remainder);
      checks++;
      if (prod !== 64'(a) || remainder >= b || lat !== 33 || dbz !== 1'b0) begin
        errors++;
        $display("FAIL rand %h/%h got q%h r%h lat%0d dbz%b want q*d+r=a r<d lat33 dbz0",
                 a, b, quotient, remainder, lat, dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_small();
    test_dbz();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
